ca_lockin_engine: RTL

//  Parametrised single-clock coherent-average + lock-in engine; successor to the separate CA + short-lockin chain.

---
 rtl/ca_lockin_pkg.sv | 51 +++++
 rtl/ca_lockin_ref_lut.sv | 30 +++
 rtl/ca_lockin_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ca_lockin_pkg.sv
// Shared types and elaboration-time helpers for the coherent-average lock-in engine.
// No logic: widths, state encoding and the integer-only cos/sin table generator.
// Backpressure: n/a.
package ca_lockin_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, READOUT, DONE} state_e;

    function automatic int q_acc_w(input int q_in, input int max_log2_nca);
        return q_in + max_log2_nca;
    endfunction

    function automatic int q_sum_w(input int q_in, input int ref_w, input int log2_m);
        return q_in + ref_w + log2_m + 1;
    endfunction

    localparam longint FX_ONE = 64'sd1 << 30;
    localparam longint PI_FX  = 64'sd3373259426;

    // Fixed-point Taylor series on the first quadrant, then quadrant folding, so the
    // table is exact-integer and identical across tools (no real math at elaboration).
    function automatic int ref_val(input int k, input int log2_m, input int ref_w,
                                   input bit want_sin);
        longint quarter, quad, r, phi, phi2, term_c, term_s, c, s, amp, cv, sv, res;
        quarter = longint'(1) << (log2_m - 2);
        quad    = (longint'(k) / quarter) % 4;
        r       = longint'(k) % quarter;
        phi     = (2 * PI_FX * r) / (longint'(1) << log2_m);
        phi2    = (phi * phi) >>> 30;
        term_c  = FX_ONE;
        term_s  = phi;
        c       = FX_ONE;
        s       = phi;
        for (int n = 1; n <= 10; n++) begin
            term_c = -((term_c * phi2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            term_s = -((term_s * phi2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            c      = c + term_c;
            s      = s + term_s;
        end
        amp = (longint'(1) << (ref_w - 1)) - 1;
        cv  = (c * amp + (FX_ONE >>> 1)) >>> 30;
        sv  = (s * amp + (FX_ONE >>> 1)) >>> 30;
        case (quad)
            0:       res = want_sin ? sv  : cv;
            1:       res = want_sin ? cv  : -sv;
            2:       res = want_sin ? -sv : -cv;
            default: res = want_sin ? -cv : sv;
        endcase
        return int'(res);
    endfunction

endpackage

// File: rtl/ca_lockin_ref_lut.sv
// Combinational k -> {cos, sin} reference table, contents fixed at elaboration.
// Latency: 0 cycles (pure lookup).
// Backpressure: none, always answers.
module ca_lockin_ref_lut
    import ca_lockin_pkg::*;
#(
    parameter int LOG2_M = 7,
    parameter int REF_W  = 16
) (
    input  logic [LOG2_M-1:0]       k_i,
    output logic signed [REF_W-1:0] cos_o,
    output logic signed [REF_W-1:0] sin_o
);

    localparam int M = 1 << LOG2_M;

    logic signed [REF_W-1:0] cos_tab [M];
    logic signed [REF_W-1:0] sin_tab [M];

    for (genvar g = 0; g < M; g++) begin : g_tab
        localparam logic signed [REF_W-1:0] COS_V = REF_W'(ref_val(g, LOG2_M, REF_W, 1'b0));
        localparam logic signed [REF_W-1:0] SIN_V = REF_W'(ref_val(g, LOG2_M, REF_W, 1'b1));
        assign cos_tab[g] = COS_V;
        assign sin_tab[g] = SIN_V;
    end

    assign cos_o = cos_tab[k_i];
    assign sin_o = sin_tab[k_i];

endmodule

// File: rtl/ca_lockin_engine.sv
// Coherent average of 2^log2_n_ca periods of M samples, then cos/sin demodulation of the average.
// Latency: data_out_valid M+2 cycles after READOUT entry; optional avg stream under CA_LI_AVG_STREAM_EN.
// Backpressure: x_ready high only while accumulating; one sample per cycle, x_valid gaps allowed.
module ca_lockin_engine
    import ca_lockin_pkg::*;
#(
    parameter int    LOG2_M       = 7,
    parameter int    Q_IN         = 14,
    parameter int    MAX_LOG2_NCA = 13,
    parameter int    REF_W        = 16,
    localparam int   Q_ACC        = q_acc_w(Q_IN, MAX_LOG2_NCA),
    localparam int   Q_SUM        = q_sum_w(Q_IN, REF_W, LOG2_M),
    localparam int   L2W          = $clog2(MAX_LOG2_NCA + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [L2W-1:0]          log2_n_ca,
    input  logic signed [Q_IN-1:0]  x,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic signed [Q_SUM-1:0] data_out_fase,
    output logic signed [Q_SUM-1:0] data_out_cuad,
    output logic                    data_out_valid,
`ifdef CA_LI_AVG_STREAM_EN
    output logic signed [Q_IN:0]    avg_out,
    output logic [LOG2_M-1:0]       avg_out_idx,
    output logic                    avg_out_valid,
`endif
    output logic                    busy
);

    localparam int M      = 1 << LOG2_M;
    localparam int PER_W  = MAX_LOG2_NCA;
    localparam int CNT_W  = LOG2_M + 2;
    localparam int PROD_W = Q_IN + 1 + REF_W;

    state_e                  state_q, state_d;
    logic [LOG2_M-1:0]       idx_q, idx_d;
    logic [PER_W-1:0]        per_q, per_d;
    logic [L2W-1:0]          l2_q, l2_d;
    logic [CNT_W-1:0]        rd_q, rd_d;

    logic signed [Q_ACC-1:0] buf_q [M];
    logic signed [PROD_W-1:0] prod_c_q, prod_s_q;
    logic                    s1_vld_q;
    logic signed [Q_SUM-1:0] acc_c_q, acc_s_q;
    logic signed [Q_SUM-1:0] fase_q, cuad_q;
    logic                    dvld_q;

    logic                    accept, per_last, last_smp, rd_active, rd_final;
    logic [L2W-1:0]          l2_clamp;
    logic signed [Q_ACC-1:0] x_ext, shifted;
    logic signed [Q_IN:0]    avg;
    logic [LOG2_M-1:0]       rd_k;
    logic signed [REF_W-1:0] ref_cos, ref_sin;

    assign l2_clamp  = (log2_n_ca > L2W'(MAX_LOG2_NCA)) ? L2W'(MAX_LOG2_NCA) : log2_n_ca;
    assign accept    = x_valid && (state_q == ACCUM);
    // Last period index is 2^l2 - 1, i.e. the low l2 bits all set.
    assign per_last  = (per_q == ~({PER_W{1'b1}} << l2_q));
    assign last_smp  = accept && (&idx_q) && per_last;
    assign x_ext     = Q_ACC'(x);

    assign rd_k      = rd_q[LOG2_M-1:0];
    assign rd_active = (state_q == READOUT) && (rd_q < CNT_W'(M));
    assign rd_final  = (state_q == READOUT) && (rd_q == CNT_W'(M + 1));
    assign shifted   = buf_q[rd_k] >>> l2_q;
    assign avg       = $signed(shifted[Q_IN:0]);

    ca_lockin_ref_lut #(
        .LOG2_M(LOG2_M),
        .REF_W (REF_W)
    ) u_ref_lut (
        .k_i  (rd_k),
        .cos_o(ref_cos),
        .sin_o(ref_sin)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        per_d   = per_q;
        l2_d    = l2_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ACCUM;
                    l2_d    = l2_clamp;
                    idx_d   = '0;
                    per_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (&idx_q) per_d = per_q + 1'b1;
                    if (last_smp) begin
                        state_d = READOUT;
                        rd_d    = '0;
                    end
                end
            end
            READOUT: begin
                rd_d = rd_q + 1'b1;
                if (rd_final) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            per_q   <= '0;
            l2_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            l2_q    <= l2_d;
            rd_q    <= rd_d;
        end
    end

    // First period overwrites, so the buffer never needs a clear pass.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[idx_q] <= (per_q == '0) ? x_ext : buf_q[idx_q] + x_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_c_q <= '0;
            prod_s_q <= '0;
            s1_vld_q <= 1'b0;
            acc_c_q  <= '0;
            acc_s_q  <= '0;
            fase_q   <= '0;
            cuad_q   <= '0;
            dvld_q   <= 1'b0;
        end else begin
            prod_c_q <= avg * ref_cos;
            prod_s_q <= avg * ref_sin;
            s1_vld_q <= rd_active && !abort;
            if (state_q != READOUT) begin
                acc_c_q <= '0;
                acc_s_q <= '0;
            end else if (s1_vld_q) begin
                acc_c_q <= acc_c_q + Q_SUM'(prod_c_q);
                acc_s_q <= acc_s_q + Q_SUM'(prod_s_q);
            end
            dvld_q <= rd_final && !abort;
            if (rd_final && !abort) begin
                fase_q <= acc_c_q;
                cuad_q <= acc_s_q;
            end
        end
    end

`ifdef CA_LI_AVG_STREAM_EN
    logic signed [Q_IN:0]  avg_q;
    logic [LOG2_M-1:0]     avg_idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avg_q     <= '0;
            avg_idx_q <= '0;
        end else if (rd_active) begin
            avg_q     <= avg;
            avg_idx_q <= rd_k;
        end
    end

    assign avg_out       = avg_q;
    assign avg_out_idx   = avg_idx_q;
    assign avg_out_valid = s1_vld_q;
`endif

    assign x_ready        = (state_q == ACCUM);
    assign busy           = (state_q == ACCUM) || (state_q == READOUT);
    assign data_out_fase  = fase_q;
    assign data_out_cuad  = cuad_q;
    assign data_out_valid = dvld_q;

endmodule
